// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch-side handshake and redirect bundle for pc_gen
interface pc_gen_if #(
  parameter int CPU_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 boot_en;
  logic                 halt_req;
  logic                 stall;
  logic                 redir_valid;
  logic [CPU_WIDTH-1:0] redir_pc;
  logic                 trap_valid;
  logic [CPU_WIDTH-1:0] trap_pc;
  logic                 pc_ready;
  logic                 pc_valid;
  logic [CPU_WIDTH-1:0] curr_pc;
  logic                 pc_update;
  logic                 misalign;
  logic [CNT_WIDTH-1:0] fetch_cnt;

  modport master (
    input  boot_en, halt_req, stall, redir_valid, redir_pc,
           trap_valid, trap_pc, pc_ready,
    output pc_valid, curr_pc, pc_update, misalign, fetch_cnt
  );

  modport slave (
    output boot_en, halt_req, stall, redir_valid, redir_pc,
           trap_valid, trap_pc, pc_ready,
    input  pc_valid, curr_pc, pc_update, misalign, fetch_cnt
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter generator with boot/run/halt control
// Trap beats redirect beats halt beats sequential advance; fetches are counted on every handshake.
module pc_gen #(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0,
  parameter int                   PC_STEP   = 4,
  parameter int                   CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_gen_if.master    bus
);
  localparam logic [CPU_WIDTH-1:0] LOW_MASK = CPU_WIDTH'(PC_STEP - 1);
  localparam logic [CPU_WIDTH-1:0] STEP_INC = CPU_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [CPU_WIDTH-1:0] r_curr_pc;
  logic [CPU_WIDTH-1:0] w_next_pc;
  logic [CPU_WIDTH-1:0] w_target;
  logic                 r_pc_update;
  logic                 w_load;
  logic                 r_misalign;
  logic                 w_misalign;
  logic [CNT_WIDTH-1:0] r_fetch_cnt;
  logic                 w_pc_valid;
  logic                 w_fire;

  assign w_pc_valid = (r_state == S_RUN);
  assign w_fire     = w_pc_valid & bus.pc_ready;
  assign w_target   = bus.trap_valid ? bus.trap_pc : bus.redir_pc;

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_curr_pc;
    w_load       = 1'b0;
    w_misalign   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.boot_en) w_next_state = S_RUN;
      end
      S_RUN, S_HALT: begin
        if (bus.trap_valid || bus.redir_valid) begin
          w_next_state = S_RUN;
          w_next_pc    = w_target & ~LOW_MASK;
          w_load       = 1'b1;
          w_misalign   = |(w_target & LOW_MASK);
        end else if (r_state == S_RUN) begin
          // A fire in the halt cycle is still counted but must not move the PC.
          if (bus.halt_req) begin
            w_next_state = S_HALT;
          end else if (w_fire && !bus.stall) begin
            w_next_pc = r_curr_pc + STEP_INC;
            w_load    = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_curr_pc   <= RESET_PC;
      r_pc_update <= 1'b0;
      r_misalign  <= 1'b0;
      r_fetch_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_curr_pc   <= w_next_pc;
      r_pc_update <= w_load;
      r_misalign  <= w_misalign;
      if (w_fire) r_fetch_cnt <= r_fetch_cnt + 1'b1;
    end
  end

  assign bus.pc_valid  = w_pc_valid;
  assign bus.curr_pc   = r_curr_pc;
  assign bus.pc_update = r_pc_update;
  assign bus.misalign  = r_misalign;
  assign bus.fetch_cnt = r_fetch_cnt;
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - vector table, directed corners and randomized model check for pc_gen
module tb_pc_gen;
  logic clk;
  logic rst_n;

  pc_gen_if #(.CPU_WIDTH(32), .CNT_WIDTH(16)) bus ();
  pc_gen_if #(.CPU_WIDTH(32), .CNT_WIDTH(2))  bus2 ();

  pc_gen #(.CPU_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  pc_gen #(.CPU_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4), .CNT_WIDTH(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus2.boot_en     = bus.boot_en;
  assign bus2.halt_req    = bus.halt_req;
  assign bus2.stall       = bus.stall;
  assign bus2.redir_valid = bus.redir_valid;
  assign bus2.redir_pc    = bus.redir_pc;
  assign bus2.trap_valid  = bus.trap_valid;
  assign bus2.trap_pc     = bus.trap_pc;
  assign bus2.pc_ready    = bus.pc_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 running, 2 halted
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_upd;
  logic        m_mis;
  int          m_cnt;

  typedef struct {
    logic [5:0]  ctl;   // {boot, halt, stall, redir, trap, ready}
    logic [31:0] rpc;
    logic [31:0] tpc;
    logic [31:0] e_pc;
    logic [2:0]  e_flg; // {valid, update, misalign}
    int          e_cnt;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic [5:0] ctl, logic [31:0] rpc, logic [31:0] tpc,
                              logic [31:0] pc, logic [2:0] flg, int cnt);
    vec_t v;
    v.ctl = ctl; v.rpc = rpc; v.tpc = tpc; v.e_pc = pc; v.e_flg = flg; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_upd = 1'b0; m_mis = 1'b0; m_cnt = 0;
  endtask

  task automatic model_update();
    bit          fire;
    logic [31:0] tgt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fire  = (m_mode == 1) && bus.pc_ready;
    m_upd = 1'b0;
    m_mis = 1'b0;
    if (fire) m_cnt++;
    if (m_mode == 0) begin
      if (bus.boot_en) m_mode = 1;
    end else if (bus.trap_valid || bus.redir_valid) begin
      tgt    = bus.trap_valid ? bus.trap_pc : bus.redir_pc;
      m_pc   = tgt - (tgt % 4);
      m_mis  = (tgt % 4) != 0;
      m_upd  = 1'b1;
      m_mode = 1;
    end else if (m_mode == 1 && bus.halt_req) begin
      m_mode = 2;
    end else if (m_mode == 1 && fire && !bus.stall) begin
      m_pc  = m_pc + 32'd4;
      m_upd = 1'b1;
    end
  endtask

  task automatic set_in(logic [5:0] ctl, logic [31:0] rpc, logic [31:0] tpc);
    {bus.boot_en, bus.halt_req, bus.stall, bus.redir_valid, bus.trap_valid, bus.pc_ready} = ctl;
    bus.redir_pc = rpc;
    bus.trap_pc  = tpc;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [31:0] pc, logic [2:0] flg, int cnt);
    chk({tag, ".curr_pc"},   64'(bus.curr_pc),   64'(pc));
    chk({tag, ".flags"},     64'({bus.pc_valid, bus.pc_update, bus.misalign}), 64'(flg));
    chk({tag, ".fetch_cnt"}, 64'(bus.fetch_cnt), 64'(cnt & 32'hFFFF));
    chk({tag, ".cnt2"},      64'(bus2.fetch_cnt), 64'(cnt & 3));
  endtask

  task automatic chk_model(string tag);
    chk_out(tag, m_pc, {m_mode == 1, m_upd, m_mis}, m_cnt);
  endtask

  initial begin
    tbl[0]  = mk(6'b100001, 32'h0,        32'h0,  32'h0,        3'b100, 0);
    tbl[1]  = mk(6'b100001, 32'h0,        32'h0,  32'h4,        3'b110, 1);
    tbl[2]  = mk(6'b100001, 32'h0,        32'h0,  32'h8,        3'b110, 2);
    tbl[3]  = mk(6'b100001, 32'h0,        32'h0,  32'hC,        3'b110, 3);
    tbl[4]  = mk(6'b100001, 32'h0,        32'h0,  32'h10,       3'b110, 4);
    tbl[5]  = mk(6'b100100, 32'h100,      32'h0,  32'h100,      3'b110, 4);
    tbl[6]  = mk(6'b100000, 32'h0,        32'h0,  32'h100,      3'b100, 4);
    tbl[7]  = mk(6'b100000, 32'h0,        32'h0,  32'h100,      3'b100, 4);
    tbl[8]  = mk(6'b100000, 32'h0,        32'h0,  32'h100,      3'b100, 4);
    tbl[9]  = mk(6'b100001, 32'h0,        32'h0,  32'h104,      3'b110, 5);
    tbl[10] = mk(6'b101001, 32'h0,        32'h0,  32'h104,      3'b100, 6);
    tbl[11] = mk(6'b101111, 32'h200,      32'h80, 32'h80,       3'b110, 7);
    tbl[12] = mk(6'b100100, 32'h1003,     32'h0,  32'h1000,     3'b111, 7);
    tbl[13] = mk(6'b100000, 32'h0,        32'h0,  32'h1000,     3'b100, 7);
    tbl[14] = mk(6'b100100, 32'h40,       32'h0,  32'h40,       3'b110, 7);
    tbl[15] = mk(6'b110001, 32'h0,        32'h0,  32'h40,       3'b000, 8);
    for (int i = 16; i <= 20; i++)
      tbl[i] = mk(6'b100001, 32'h0,       32'h0,  32'h40,       3'b000, 8);
    tbl[21] = mk(6'b100101, 32'h300,      32'h0,  32'h300,      3'b110, 8);
    tbl[22] = mk(6'b100100, 32'h300,      32'h0,  32'h300,      3'b110, 8);
    tbl[23] = mk(6'b100100, 32'hFFFFFFFC, 32'h0,  32'hFFFFFFFC, 3'b110, 8);
    tbl[24] = mk(6'b100001, 32'h0,        32'h0,  32'h0,        3'b110, 9);
    tbl[25] = mk(6'b110010, 32'h0,        32'h22, 32'h20,       3'b111, 9);

    rst_n = 1'b0;
    set_in(6'b000000, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 32'h0, 3'b000, 0);
    rst_n = 1'b1;

    // Redirect, trap and halt must all be ignored while idle
    set_in(6'b011111, 32'h500, 32'h600);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("idle_ignore", 32'h0, 3'b000, 0);
    end

    for (int i = 0; i < 26; i++) begin
      set_in(tbl[i].ctl, tbl[i].rpc, tbl[i].tpc);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_flg, tbl[i].e_cnt);
    end

    for (int i = 0; i < 600; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom % 8 == 0) ? (32'hFFFFFFF8 | 32'($urandom % 8)) : $urandom;
      bus.boot_en     = ($urandom % 4) != 0;
      bus.halt_req    = ($urandom % 10) == 0;
      bus.stall       = ($urandom % 4) == 0;
      bus.redir_valid = ($urandom % 9) == 0;
      bus.trap_valid  = ($urandom % 17) == 0;
      bus.pc_ready    = ($urandom % 3) != 0;
      bus.redir_pc    = rpc;
      bus.trap_pc     = $urandom;
      step();
      chk_model($sformatf("rand%0d", i));
    end

    // Asynchronous reset between edges with a redirect pending
    set_in(6'b101111, 32'h1234, 32'h5678);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_out("async_rst", 32'h0, 3'b000, 0);
    step();
    chk_out("rst_hold", 32'h0, 3'b000, 0);
    rst_n = 1'b1;
    #2;
    chk_out("rst_release", 32'h0, 3'b000, 0);
    set_in(6'b100001, 32'h0, 32'h0);
    step();
    chk_model("reboot0");
    step();
    chk_model("reboot1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
